// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit common-anode 7-segment scan driver
// Per-frame digit snapshot, one-cycle blank between slots, hours-tens zero blanking, blinking dp.
module seg7_scan_driver #(
   parameter int DIGIT_CYCLES = 100_000,
   parameter int BLINK_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit1_min,
   input  logic [3:0] digit2_min,
   input  logic [3:0] digit3_hour,
   input  logic [3:0] digit4_hour,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = $clog2(DIGIT_CYCLES);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
   localparam logic [6:0]    SEG_OFF    = 7'b1111111;

   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [1:0]        idx_q,    idx_d;
   logic [BW-1:0]     bcnt_q,   bcnt_d;
   logic              phase_q,  phase_d;
   logic [3:0][3:0]   shadow_q, shadow_d;
   logic [3:0]        an_q,     an_d;
   logic [6:0]        seg_q,    seg_d;
   logic              dp_q,     dp_d;
   logic [3:0]        cur_digit;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         bcnt_q   <= '0;
         phase_q  <= 1'b0;
         shadow_q <= '0;
         an_q     <= 4'b1111;
         seg_q    <= SEG_OFF;
         dp_q     <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         bcnt_q   <= bcnt_d;
         phase_q  <= phase_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (bcnt_q == BLINK_LAST) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end else begin
         bcnt_d = bcnt_q + 1'b1;
      end
   end

   // Inputs are only sampled at the start of slot 0 so a frame never mixes old and new digits.
   always_comb begin
      shadow_d = shadow_q;
      if (cnt_q == '0 && idx_q == 2'd0) begin
         shadow_d = {digit4_hour, digit3_hour, digit2_min, digit1_min};
      end
   end

   assign cur_digit = shadow_q[idx_q];

   always_comb begin
      an_d  = 4'b1111;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (cnt_q != '0 && !(idx_q == 2'd3 && cur_digit == 4'd0)) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = decode(cur_digit);
         dp_d  = ~(idx_q == 2'd2 && phase_q);
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
